seven_seg_scan_driver: RTL

Upstream companion of seven_seg_decoder. Holds NUM_DIGITS BCD digits plus decimal points in a display register and time-multiplexes them onto one common-anode 7-segment bus. Drives active-low anode selects, and drives segments through an internal seven_seg_decoder instance. Adds a prescaled scan, an anti-ghosting blank window at the start of each slot, and optional leading-zero blanking.

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seven_seg_decoder.sv | 29 ++
 rtl/seven_seg_scan_driver.sv | 113 +++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seven_seg_pkg;

  // Width of one BCD digit
  localparam int BCD_W = 4;

  // All segments off (active-low bus)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Inactive level of one anode select (active low)
  localparam logic AN_OFF = 1'b1;

  // Inactive level of the decimal point (active low)
  localparam logic DP_OFF = 1'b1;

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD to active-low 7-segment decoder, {a,b,c,d,e,f,g} ordering.
// Latency: combinational.
// Backpressure: none; non-BCD codes decode to all segments off.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  // Segment pattern lookup; anything outside 0-9 stays dark
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode driver for NUM_DIGITS BCD digits with blank window and leading-zero blanking.
// Latency: outputs are registered and lag the scan counters by one cycle; load visible one cycle after capture.
// Backpressure: none; load is accepted every cycle, last load wins.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic                        load,
  input  logic                        blank_lz,
  output logic [NUM_DIGITS-1:0]       an_out,
  output logic [6:0]                  seg_out,
  output logic                        dp_out
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [BCD_W*NUM_DIGITS-1:0] disp_reg;
  logic [NUM_DIGITS-1:0]       dp_reg;
  logic [CNT_W-1:0]            cnt;
  logic [IDX_W-1:0]            idx;

  logic [NUM_DIGITS-1:0]       en;
  logic                        zeros_up;
  logic [BCD_W-1:0]            cur_digit;
  logic                        cur_dp;
  logic                        cur_en;
  logic                        lit;
  logic [6:0]                  dec_seg;
  logic [NUM_DIGITS-1:0]       an_next;

  // Digit k is dark when blanking is on and it and every digit above it is zero; digit 0 always shows
  always_comb begin
    zeros_up = 1'b1;
    en       = '1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zeros_up = zeros_up && (disp_reg[k*BCD_W +: BCD_W] == '0);
      en[k]    = !(blank_lz && zeros_up);
    end
  end

  // Select the nibble, decimal point and enable of the digit currently being scanned
  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_digit = disp_reg[k*BCD_W +: BCD_W];
        cur_dp    = dp_reg[k];
        cur_en    = en[k];
      end
    end
  end

  seven_seg_decoder u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Lit only after the anti-ghosting window and when the digit is not blanked
  always_comb begin
    lit = (cnt >= CNT_W'(BLANK_CYCLES)) && cur_en;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_next[k] = (lit && (idx == IDX_W'(k))) ? ~AN_OFF : AN_OFF;
    end
  end

  // Slot prescaler and digit index; index advances when the prescaler wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_W'(PRESCALE - 1)) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Display register capture; the scan position is left untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_reg <= '0;
      dp_reg   <= '0;
    end else if (load) begin
      disp_reg <= digits_in;
      dp_reg   <= dp_in;
    end
  end

  // Registered pin drivers from the pre-edge scan position and display contents
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_out  <= {NUM_DIGITS{AN_OFF}};
      seg_out <= SEG_BLANK;
      dp_out  <= DP_OFF;
    end else begin
      an_out  <= an_next;
      seg_out <= lit ? dec_seg : SEG_BLANK;
      dp_out  <= lit ? ~cur_dp : DP_OFF;
    end
  end

endmodule
